sos_sample_feeder: RTL and testbench
====================================

# sos_sample_feeder

Initiator side of the `sample_trig`/`filter_done` handshake used by the cascaded SOS filter chain. Samples arrive on a valid/ready input and are buffered in a small FIFO. At a fixed sample rate derived from `clk`, one sample is presented to the filter chain with a single-cycle trigger. The block then waits for the chain's done pulse, captures the filtered result and flags overrun, underrun and timeout conditions.

## Interface
Parameters:
- `DATA_SIZE`, 24, sample width in bits (matches filter chain).
- `FIFO_DEPTH`, 4, input FIFO entries; power of 2, ≥2.
- `DIV`, 1024, `clk` cycles per sample period; ≥4.
- `TIMEOUT`, 255, max cycles to wait for `filt_done` after trigger; ≥1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_SIZE  upstream sample.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  FIFO not full; push when `in_valid && in_ready`.
- `filt_data`  out  DATA_SIZE  to filter chain `data_in`.
- `filt_trig`  out  1  to filter chain `sample_trig`; single-cycle pulse.
- `filt_result`  in  DATA_SIZE  from filter chain `data_out`.
- `filt_done`  in  1  from last stage `filter_done`; single-cycle pulse.
- `out_data`  out  DATA_SIZE  captured filtered sample.
- `out_valid`  out  1  single-cycle pulse, new `out_data`.
- `clear_err`  in  1  clears sticky error flags.
- `overrun`  out  1  sticky: tick arrived while chain busy.
- `underrun`  out  1  sticky: tick arrived with FIFO empty.
- `timeout_err`  out  1  sticky: `filt_done` not seen within `TIMEOUT`.

## Operation
- **Reset:** FSM in IDLE. Rate counter, FIFO pointers and timeout counter cleared.
  - Outputs at reset: `filt_data`=0, `filt_trig`=0, `out_data`=0, `out_valid`=0, all error flags 0, `in_ready`=1.
  - Reset asserted mid-operation aborts any pending transaction and flushes the FIFO.
- **FIFO:** `in_ready = !full`, combinational from pointers.
  - A push is never accepted when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when neither full nor empty: both occur; occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Rate counter:** counts 0..DIV-1 and wraps. `tick` is asserted internally when count == DIV-1, producing one tick every `DIV` cycles.
- **FSM states:**
  - **IDLE:**
    - On `tick` with FIFO non-empty: pop the head into `filt_data`, assert `filt_trig` on the next cycle, clear the timeout counter, go to WAIT.
    - On `tick` with FIFO empty: set `underrun`; no trigger.
    - `filt_done` in IDLE is ignored.
  - **WAIT:**
    - On `filt_done`: register `filt_result` into `out_data`, pulse `out_valid`, return to IDLE.
    - Otherwise increment the timeout counter. If it reaches `TIMEOUT`: set `timeout_err`, return to IDLE, no `out_valid`, `out_data` unchanged.
    - `tick` in WAIT sets `overrun`. The tick is dropped; no pop occurs and the sample remains in the FIFO.
    - `filt_done` and timeout in the same cycle: `filt_done` wins; no error is flagged.
- **Error flags:** sticky until `clear_err`. If a set event and `clear_err` occur in the same cycle, set wins.
- **Data widths:** all data paths are `DATA_SIZE` bits, passed unmodified; no arithmetic on data.

## Timing
- The FIFO write at edge N makes data poppable from edge N+1.
- For a tick at cycle T:
  - `filt_data` updates at edge T+1.
  - `filt_trig` is high for exactly cycle T+1.
  - `filt_data` is held stable until the next trigger, satisfying the filter's requirement that input be stable for the whole computation.
- For `filt_done` at cycle D:
  - `out_data` and `out_valid` update at edge D+1.
  - `out_valid` is high for one cycle; `out_data` is held until the next capture.
- Minimum spacing between `filt_trig` pulses is `DIV` cycles.
- Throughput: one sample per `DIV` cycles, provided chain latency + 2 < `DIV`.

## Test plan
Bench parameters: `DATA_SIZE`=24, `FIFO_DEPTH`=4, `DIV`=16, `TIMEOUT`=8. Filter model returns `data+1` five cycles after trigger.

- **Reset then stream:** reset, push 0x000010, 0x000020, 0x000030. Required: `filt_trig` pulses at cycles 16, 32, 48 after reset release; `out_valid` with 0x000011, 0x000021, 0x000031 six cycles after each trigger; no error flags.
- **FIFO full:** hold `in_valid` with no ticks consumed. Required: `in_ready` drops after 4 accepted pushes; a 5th push with a simultaneous pop is not accepted; the 5th value is never seen on `filt_data`.
- **Underrun:** no input for 20 cycles. Required: `underrun`=1 after the first tick, no `filt_trig`; `clear_err` returns it to 0.
- **Overrun/timeout:** filter model never asserts done. Required: `timeout_err`=1 nine cycles after the trigger; no `out_valid`; with `TIMEOUT`=255, the next tick sets `overrun` and the FIFO count is unchanged.
- **Done vs timeout collision:** `filt_done` on the same cycle the timeout count is reached. Required: `out_valid` asserted, `timeout_err` stays 0.
- **Mid-WAIT reset:** reset asserted 2 cycles after a trigger. Required: all outputs 0 immediately (asynchronous); FIFO empty; a late `filt_done` after release produces no `out_valid`.

Source files
------------

// File: rtl/sos_sample_feeder.sv
// Sample feeder for the cascaded SOS filter chain: buffers upstream samples,
// triggers the chain once per rate period and captures its result.
module sos_sample_feeder #(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = 1024,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_SIZE-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_SIZE-1:0]          filt_data,
    output logic                          filt_trig,
    input  logic [DATA_SIZE-1:0]          filt_result,
    input  logic                          filt_done,
    output logic [DATA_SIZE-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          clear_err,
    output logic                          overrun,
    output logic                          underrun,
    output logic                          timeout_err,
    output logic                          dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;

    logic [CW-1:0]        rate_cnt_q, rate_cnt_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;

    logic [DATA_SIZE-1:0] filt_data_q, filt_data_d;
    logic                 filt_trig_q, filt_trig_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 underrun_q, underrun_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 to_hit;
    logic                 capture;
    logic                 set_overrun;
    logic                 set_underrun;
    logic                 set_timeout;

    // Upstream handshake: a sample transfers on any rising edge where
    // in_valid && in_ready; in_ready depends only on the FIFO pointers, never on in_valid.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = in_valid && !full;
    assign tick  = (rate_cnt_q == CNT_LAST);

    // The timeout fires only when no done is present, so a colliding done wins.
    assign to_hit = (state_q == ST_WAIT) && !filt_done && (to_cnt_q == TO_LIMIT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && !empty) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (filt_done || to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        capture      = (state_q == ST_WAIT) && filt_done;
        set_overrun  = (state_q == ST_WAIT) && tick;
        set_underrun = (state_q == ST_IDLE) && tick && empty;
        set_timeout  = to_hit;

        filt_trig_d  = pop;
        filt_data_d  = pop ? mem_q[rd_ptr_q[AW-1:0]] : filt_data_q;
        out_valid_d  = capture;
        out_data_d   = capture ? filt_result : out_data_q;

        to_cnt_d = to_cnt_q;
        if (pop) begin
            to_cnt_d = '0;
        end else if ((state_q == ST_WAIT) && !filt_done && !to_hit) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end

        overrun_d     = set_overrun  ? 1'b1 : (clear_err ? 1'b0 : overrun_q);
        underrun_d    = set_underrun ? 1'b1 : (clear_err ? 1'b0 : underrun_q);
        timeout_err_d = set_timeout  ? 1'b1 : (clear_err ? 1'b0 : timeout_err_q);
    end

    // FIFO storage and pointers; pointers carry one extra wrap bit.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
        end
        wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        rate_cnt_d = tick ? '0 : (rate_cnt_q + CNT_ONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rate_cnt_q    <= '0;
            to_cnt_q      <= '0;
            filt_data_q   <= '0;
            filt_trig_q   <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rate_cnt_q    <= rate_cnt_d;
            to_cnt_q      <= to_cnt_d;
            filt_data_q   <= filt_data_d;
            filt_trig_q   <= filt_trig_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready    = !full;
    assign filt_data   = filt_data_q;
    assign filt_trig   = filt_trig_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;
    assign dbg_level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_sos_sample_feeder.sv
// Directed bench for sos_sample_feeder: a main instance (TIMEOUT=8) with a
// behavioural filter model, plus a TIMEOUT=255 instance for the overrun case.
module tb_sos_sample_feeder;

    localparam int DW = 24;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] filt_data;
    logic          filt_trig;
    logic [DW-1:0] filt_result;
    logic          filt_done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          clear_err;
    logic          overrun;
    logic          underrun;
    logic          timeout_err;
    logic          dbg_state;
    logic [2:0]    dbg_level;

    logic          in_valid2;
    logic          in_ready2;
    logic [DW-1:0] filt_data2;
    logic          filt_trig2;
    logic [DW-1:0] filt_result2;
    logic          filt_done2;
    logic [DW-1:0] out_data2;
    logic          out_valid2;
    logic          overrun2;
    logic          underrun2;
    logic          timeout_err2;
    logic          dbg_state2;
    logic [2:0]    dbg_level2;

    int            checks;
    int            errors;

    logic          model_on;
    logic          model_kill;
    int            model_delay;
    int            pend;
    logic [DW-1:0] res;

    sos_sample_feeder #(
        .DATA_SIZE(DW), .FIFO_DEPTH(4), .DIV(16), .TIMEOUT(8)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filt_data(filt_data), .filt_trig(filt_trig),
        .filt_result(filt_result), .filt_done(filt_done),
        .out_data(out_data), .out_valid(out_valid),
        .clear_err(clear_err),
        .overrun(overrun), .underrun(underrun), .timeout_err(timeout_err),
        .dbg_state(dbg_state), .dbg_level(dbg_level)
    );

    sos_sample_feeder #(
        .DATA_SIZE(DW), .FIFO_DEPTH(4), .DIV(16), .TIMEOUT(255)
    ) u_ovr (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid2), .in_ready(in_ready2),
        .filt_data(filt_data2), .filt_trig(filt_trig2),
        .filt_result(filt_result2), .filt_done(filt_done2),
        .out_data(out_data2), .out_valid(out_valid2),
        .clear_err(clear_err),
        .overrun(overrun2), .underrun(underrun2), .timeout_err(timeout_err2),
        .dbg_state(dbg_state2), .dbg_level(dbg_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter model: done (with data+1) is high for the cycle model_delay after the trigger.
    initial begin
        pend        = 0;
        res         = '0;
        filt_done   = 1'b0;
        filt_result = '0;
    end

    always @(negedge clk) begin
        filt_done = 1'b0;
        if (model_kill) begin
            pend = 0;
        end else if (filt_trig && model_on) begin
            pend = model_delay;
            res  = filt_data + 24'd1;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                filt_done   = 1'b1;
                filt_result = res;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0: reset just released, no edge yet seen.
    task automatic do_reset();
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        in_data    = '0;
        clear_err  = 1'b0;
        model_kill = 1'b1;
        step(3);
        model_kill = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (filt_data !== 24'h0 || filt_trig !== 1'b0) begin
            errors++;
            $display("FAIL reset_filt: data=%0h trig=%0b, expected 0/0", filt_data, filt_trig);
        end
        checks++;
        if (out_data !== 24'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: data=%0h valid=%0b, expected 0/0", out_data, out_valid);
        end
        checks++;
        if ({overrun, underrun, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {overrun, underrun, timeout_err});
        end
        checks++;
        if (in_ready !== 1'b1 || dbg_state !== 1'b0 || dbg_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo: ready=%0b state=%0b level=%0d, expected 1/0/0",
                     in_ready, dbg_state, dbg_level);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        logic          exp_trig;
        logic          exp_ov;
        logic [DW-1:0] exp_fd;
        logic [DW-1:0] exp_od;
        vals[0] = 24'h000010;
        vals[1] = 24'h000020;
        vals[2] = 24'h000030;
        do_reset();
        model_on    = 1'b1;
        model_delay = 5;
        for (int c = 0; c < 60; c++) begin
            in_valid = (c < 3);
            in_data  = (c < 3) ? vals[c] : 24'h0;
            exp_trig = (c == 16) || (c == 32) || (c == 48);
            exp_ov   = (c == 22) || (c == 38) || (c == 54);
            checks++;
            if (filt_trig !== exp_trig) begin
                errors++;
                $display("FAIL stream_trig c=%0d: got %0b expected %0b", c, filt_trig, exp_trig);
            end
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL stream_valid c=%0d: got %0b expected %0b", c, out_valid, exp_ov);
            end
            if (exp_trig) begin
                exp_fd = vals[(c / 16) - 1];
                checks++;
                if (filt_data !== exp_fd) begin
                    errors++;
                    $display("FAIL stream_fdata c=%0d: got %0h expected %0h", c, filt_data, exp_fd);
                end
            end
            if (exp_ov) begin
                exp_od = vals[(c - 6) / 16 - 1] + 24'd1;
                checks++;
                if (out_data !== exp_od) begin
                    errors++;
                    $display("FAIL stream_odata c=%0d: got %0h expected %0h", c, out_data, exp_od);
                end
            end
            checks++;
            if ({overrun, underrun, timeout_err} !== 3'b000) begin
                errors++;
                $display("FAIL stream_flags c=%0d: got %b expected 000", c,
                         {overrun, underrun, timeout_err});
            end
            step(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic          exp_rdy;
        logic          exp_trig;
        logic [DW-1:0] exp_fd;
        do_reset();
        model_on    = 1'b1;
        model_delay = 5;
        for (int c = 0; c < 82; c++) begin
            in_valid = (c < 16);
            in_data  = 24'h000100 + 24'(c);
            exp_rdy  = (c < 4) || (c >= 16);
            exp_trig = (c == 16) || (c == 32) || (c == 48) || (c == 64);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL full_ready c=%0d: got %0b expected %0b", c, in_ready, exp_rdy);
            end
            checks++;
            if (filt_trig !== exp_trig) begin
                errors++;
                $display("FAIL full_trig c=%0d: got %0b expected %0b", c, filt_trig, exp_trig);
            end
            if (exp_trig) begin
                exp_fd = 24'h000100 + 24'((c / 16) - 1);
                checks++;
                if (filt_data !== exp_fd) begin
                    errors++;
                    $display("FAIL full_fdata c=%0d: got %0h expected %0h", c, filt_data, exp_fd);
                end
            end
            if (c == 16) begin
                checks++;
                if (dbg_level !== 3'd3) begin
                    errors++;
                    $display("FAIL full_level: got %0d expected 3", dbg_level);
                end
            end
            if (c == 81) begin
                checks++;
                if (underrun !== 1'b1 || filt_data !== 24'h000103) begin
                    errors++;
                    $display("FAIL full_drained: underrun=%0b fdata=%0h, expected 1/103",
                             underrun, filt_data);
                end
            end
            step(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_underrun();
        logic exp_ur;
        do_reset();
        for (int c = 0; c < 33; c++) begin
            clear_err = (c == 20) || (c == 31);
            exp_ur    = ((c >= 16) && (c <= 20)) || (c == 32);
            checks++;
            if (underrun !== exp_ur) begin
                errors++;
                $display("FAIL underrun c=%0d: got %0b expected %0b", c, underrun, exp_ur);
            end
            checks++;
            if (filt_trig !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL underrun_trig c=%0d: trig=%0b overrun=%0b expected 0/0",
                         c, filt_trig, overrun);
            end
            step(1);
        end
        clear_err = 1'b0;
    endtask

    task automatic test_timeout();
        logic exp_to;
        do_reset();
        model_on = 1'b0;
        for (int c = 0; c < 31; c++) begin
            in_valid = (c == 0);
            in_data  = 24'h000055;
            exp_to   = (c >= 25);
            checks++;
            if (timeout_err !== exp_to) begin
                errors++;
                $display("FAIL timeout c=%0d: got %0b expected %0b", c, timeout_err, exp_to);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_valid c=%0d: got %0b expected 0", c, out_valid);
            end
            if (c == 16) begin
                checks++;
                if (filt_trig !== 1'b1 || filt_data !== 24'h000055) begin
                    errors++;
                    $display("FAIL timeout_trig: trig=%0b data=%0h expected 1/55", filt_trig, filt_data);
                end
            end
            if (c == 25) begin
                checks++;
                if (out_data !== 24'h0 || dbg_state !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_idle: odata=%0h state=%0b expected 0/0", out_data, dbg_state);
                end
            end
            step(1);
        end
        in_valid = 1'b0;
        model_on = 1'b1;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int c = 0; c < 33; c++) begin
            in_valid2 = (c < 2);
            in_data   = 24'h000200 + 24'(c);
            if (c == 16) begin
                checks++;
                if (filt_trig2 !== 1'b1 || filt_data2 !== 24'h000200 || dbg_level2 !== 3'd1) begin
                    errors++;
                    $display("FAIL ovr_first: trig=%0b data=%0h level=%0d expected 1/200/1",
                             filt_trig2, filt_data2, dbg_level2);
                end
            end
            if (c == 31) begin
                checks++;
                if (overrun2 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_early: got %0b expected 0", overrun2);
                end
            end
            if (c == 32) begin
                checks++;
                if (overrun2 !== 1'b1 || timeout_err2 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_set: overrun=%0b timeout=%0b expected 1/0", overrun2, timeout_err2);
                end
                checks++;
                if (filt_trig2 !== 1'b0 || dbg_level2 !== 3'd1 || dbg_state2 !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_hold: trig=%0b level=%0d state=%0b expected 0/1/1",
                             filt_trig2, dbg_level2, dbg_state2);
                end
            end
            step(1);
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        model_on    = 1'b1;
        model_delay = 8;
        for (int c = 0; c < 31; c++) begin
            in_valid = (c == 0);
            in_data  = 24'h0000AA;
            checks++;
            if (out_valid !== (c == 25)) begin
                errors++;
                $display("FAIL coll_valid c=%0d: got %0b expected %0b", c, out_valid, (c == 25));
            end
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL coll_timeout c=%0d: got %0b expected 0", c, timeout_err);
            end
            if (c == 25) begin
                checks++;
                if (out_data !== 24'h0000AB) begin
                    errors++;
                    $display("FAIL coll_data: got %0h expected ab", out_data);
                end
            end
            step(1);
        end
        in_valid    = 1'b0;
        model_delay = 5;
    endtask

    task automatic test_mid_wait_reset();
        do_reset();
        model_on    = 1'b1;
        model_delay = 8;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c == 0);
            in_data  = 24'h000077;
            if (c == 16) begin
                checks++;
                if (filt_trig !== 1'b1 || filt_data !== 24'h000077) begin
                    errors++;
                    $display("FAIL midrst_trig: trig=%0b data=%0h expected 1/77", filt_trig, filt_data);
                end
            end
            step(1);
        end
        in_valid = 1'b0;
        checks++;
        if (dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL midrst_wait: state=%0b expected 1", dbg_state);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (filt_data !== 24'h0 || filt_trig !== 1'b0 || out_data !== 24'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out: fdata=%0h trig=%0b odata=%0h valid=%0b expected all 0",
                     filt_data, filt_trig, out_data, out_valid);
        end
        checks++;
        if ({overrun, underrun, timeout_err} !== 3'b000 || dbg_level !== 3'd0 ||
            dbg_state !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: flags=%b level=%0d state=%0b ready=%0b expected 000/0/0/1",
                     {overrun, underrun, timeout_err}, dbg_level, dbg_state, in_ready);
        end
        step(2);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b0 || filt_trig !== 1'b0) begin
                errors++;
                $display("FAIL midrst_late c=%0d: valid=%0b trig=%0b expected 0/0",
                         c, out_valid, filt_trig);
            end
            step(1);
        end
        model_delay = 5;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        model_on     = 1'b1;
        model_kill   = 1'b1;
        model_delay  = 5;
        filt_result2 = '0;
        filt_done2   = 1'b0;
        test_reset();
        test_stream();
        test_fifo_full();
        test_underrun();
        test_timeout();
        test_overrun();
        test_collision();
        test_mid_wait_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
